// File: rtl/conv_apb_master_if.sv
// Command, response and p_* bus signals of the convolution-core configuration initiator.
// The master modport is the initiator's view; slave is the far side (controller plus core).
interface conv_apb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        busy;
  logic        p_sel;
  logic [3:0]  p_strb;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_ce;
  logic        p_we;
  logic        p_rdy;
  logic [31:0] p_rdata;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, p_rdy, p_rdata,
    output cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_timeout, busy,
    output p_sel, p_strb, p_addr, p_wdata, p_ce, p_we
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, p_rdy, p_rdata,
    input  cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_timeout, busy,
    input  p_sel, p_strb, p_addr, p_wdata, p_ce, p_we
  );
endinterface

// File: rtl/conv_apb_master.sv
// Queues read/write commands and replays them on the p_* configuration bus, one in-order
// response per command; rsp_valid trails p_sel by 4 cycles, 3-cycle back-to-back, ready-timeout abort.
module conv_apb_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  conv_apb_master_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  cmd_t          mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [AW-1:0] head_idx;
  cmd_t          head;
  logic          full, empty, push, pop, ok_rdy, to_hit, more, enter_setup;
  state_t        state_q, state_d;
  logic [CW-1:0] tcnt_q, tcnt_d;

  logic          p_sel_q, p_sel_d, p_ce_q, p_ce_d, p_we_q, p_we_d;
  logic [3:0]    p_strb_q, p_strb_d;
  logic [31:0]   p_addr_q, p_addr_d, p_wdata_q, p_wdata_d;
  logic          done_q, done_d, done_we_q, done_we_d, done_to_q, done_to_d;
  logic [31:0]   done_rdata_q, done_rdata_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d, rsp_to_q, rsp_to_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push     = bus.cmd_valid && !full;
  assign ok_rdy   = (state_q == ACCESS) && bus.p_rdy;
  assign to_hit   = (state_q == ACCESS) && !bus.p_rdy && (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign pop      = ok_rdy || to_hit;
  assign more     = (count > (AW+1)'(1)) || push;
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.cmd_we, bus.cmd_addr, bus.cmd_wdata};
  end

  // On a completion the next head is the entry behind the one being popped, or the
  // command arriving this very cycle when the queue is about to drain.
  always_comb begin
    head_idx = rd_ptr_q[AW-1:0];
    if (state_q == ACCESS) head_idx = rd_ptr_q[AW-1:0] + AW'(1);
    head = mem_q[head_idx];
    if (state_q == ACCESS && count == (AW+1)'(1)) head = {bus.cmd_we, bus.cmd_addr, bus.cmd_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tcnt_q       <= '0;
      p_sel_q      <= 1'b0;
      p_ce_q       <= 1'b0;
      p_we_q       <= 1'b0;
      p_strb_q     <= '0;
      p_addr_q     <= '0;
      p_wdata_q    <= '0;
      done_q       <= 1'b0;
      done_we_q    <= 1'b0;
      done_to_q    <= 1'b0;
      done_rdata_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_we_q     <= 1'b0;
      rsp_to_q     <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tcnt_q       <= tcnt_d;
      p_sel_q      <= p_sel_d;
      p_ce_q       <= p_ce_d;
      p_we_q       <= p_we_d;
      p_strb_q     <= p_strb_d;
      p_addr_q     <= p_addr_d;
      p_wdata_q    <= p_wdata_d;
      done_q       <= done_d;
      done_we_q    <= done_we_d;
      done_to_q    <= done_to_d;
      done_rdata_q <= done_rdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_we_q     <= rsp_we_d;
      rsp_to_q     <= rsp_to_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (ok_rdy)      state_d = more ? SETUP : IDLE;
        else if (to_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // p_sel is a single-cycle pulse: the slave re-decodes it once it is idle again.
  always_comb begin
    enter_setup  = (state_d == SETUP) && (state_q != SETUP);
    p_sel_d      = (state_d == SETUP);
    p_ce_d       = (state_d == ACCESS);
    p_we_d       = enter_setup ? head.we : p_we_q;
    p_strb_d     = enter_setup ? {4{head.we}} : p_strb_q;
    p_addr_d     = enter_setup ? head.addr : p_addr_q;
    p_wdata_d    = enter_setup ? head.wdata : p_wdata_q;
    tcnt_d       = (state_q == ACCESS && !pop) ? tcnt_q + CW'(1) : '0;
    done_d       = pop;
    done_we_d    = p_we_q;
    done_to_d    = to_hit;
    done_rdata_d = (ok_rdy && !p_we_q) ? bus.p_rdata : '0;
    rsp_valid_d  = done_q;
    rsp_we_d     = done_q ? done_we_q : rsp_we_q;
    rsp_to_d     = done_q ? done_to_q : rsp_to_q;
    rsp_rdata_d  = done_q ? done_rdata_q : rsp_rdata_q;
  end

  assign bus.cmd_ready   = !full;
  assign bus.busy        = !empty || (state_q != IDLE);
  assign bus.p_sel       = p_sel_q;
  assign bus.p_ce        = p_ce_q;
  assign bus.p_we        = p_we_q;
  assign bus.p_strb      = p_strb_q;
  assign bus.p_addr      = p_addr_q;
  assign bus.p_wdata     = p_wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_we      = rsp_we_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
endmodule

// File: doc/conv_apb_master.md
Name: conv_apb_master

Overview:
- Bus initiator for the convolution core's APB-style configuration port (p_sel/p_ce/p_we/p_rdy handshake).
- Accepts read/write commands from a local controller, sequencer or host bridge into a small command FIFO.
- Replays each command onto the p_* bus and returns one response per command, in order.
- Includes a ready-timeout so a non-responding slave (e.g. one still clearing its tables after reset) cannot hang the loader.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 64, max ACCESS cycles waiting for p_rdy before abort (>=2)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept (= !full)
cmd_we  input  1  1=write, 0=read
cmd_addr  input  32  target word address
cmd_wdata  input  32  write data (ignored for reads)
rsp_valid  output  1  one-cycle response pulse; no backpressure
rsp_we  output  1  echo of the completed command's cmd_we
rsp_rdata  output  32  read data (0 for writes and timeouts)
rsp_timeout  output  1  command aborted by timeout
busy  output  1  FIFO non-empty or transfer in progress
p_sel  output  1  transfer select, one-cycle pulse
p_strb  output  4  4'hF on writes, 4'h0 on reads
p_addr  output  32  address, held SETUP through ACCESS
p_wdata  output  32  write data, held SETUP through ACCESS
p_ce  output  1  access enable, high throughout ACCESS
p_we  output  1  direction, held SETUP through ACCESS
p_rdy  input  1  slave completion, one-cycle pulse
p_rdata  input  32  read data, valid while p_rdy=1

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE, timeout counter 0. All outputs 0, except cmd_ready=1.
- Handshake rules:
  - Push occurs when cmd_valid&cmd_ready at a clock edge.
  - Pop occurs at transfer completion.
  - Push and pop in the same cycle are both honoured.
  - When full, cmd_ready=0 and cmd_valid is ignored.
- All p_* and rsp_* outputs are registered. p_addr/p_wdata/p_we/p_strb load from the FIFO head on entry to SETUP and hold until the next SETUP.
- IDLE: if FIFO non-empty -> SETUP; else stay.
- SETUP: p_sel=1, p_ce=0, for exactly one cycle -> ACCESS.
  - p_sel is deliberately dropped before ACCESS. The slave decodes p_sel only in its idle state and returns to idle in the cycle p_rdy rises, so a held p_sel would trigger a duplicate transfer.
- ACCESS: p_sel=0, p_ce=1; timeout counter increments each cycle.
  - p_rdy=1 sampled: capture p_rdata (reads) or 0 (writes) into rsp_rdata. Next cycle rsp_valid=1, rsp_timeout=0. Pop. Clear counter.
    - Next state SETUP if the FIFO still holds an entry after the pop; otherwise IDLE.
  - Counter reaches TIMEOUT_CYCLES with no p_rdy: rsp_valid=1, rsp_timeout=1, rsp_rdata=0. Pop, clear counter, -> IDLE.
  - p_rdy and terminal count in the same cycle: p_rdy wins (normal completion).
- p_rdy outside ACCESS is ignored.
- Timing against the convolution core slave:
  - First p_sel 2 cycles after a push into an empty idle FIFO.
  - p_ce from cycle +1; slave p_rdy at cycle +2; rsp_valid at cycle +4 relative to p_sel.
  - Back-to-back throughput: one transfer per 3 cycles.
- rsp_valid is a single-cycle pulse with no backpressure; rsp_we/rsp_rdata/rsp_timeout hold until the next response.
- busy = FIFO non-empty or state != IDLE.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra pointer bit.
- rst asserted mid-transfer:
  - Aborts immediately; queued commands are discarded and no response is issued.
  - p_ce/p_sel drop asynchronously.

Test Plan:
1. Write addr 3 data 0x0000_1234, slave model p_rdy 1 cycle after p_ce -> p_sel one cycle with p_we=1, p_strb=F, p_addr=3, p_wdata=0x1234. Then p_ce high 2 cycles. Then rsp_valid pulse with rsp_we=1, rsp_rdata=0, rsp_timeout=0, 4 cycles after p_sel.
2. Read addr 3, slave returns 0x0000_ABCD with p_rdy -> p_we=0, p_strb=0, single rsp_valid with rsp_rdata=0xABCD.
3. Push 6 writes (addr 0..5) every cycle, FIFO_DEPTH=4 -> cmd_ready drops after FIFO fills and re-asserts on each pop. p_sel pulses exactly 3 cycles apart; 6 responses in addr order; no duplicate slave write.
4. Slave never asserts p_rdy, TIMEOUT_CYCLES=64 -> rsp_valid with rsp_timeout=1, rsp_rdata=0 after 64 ACCESS cycles. A following queued read completes normally.
5. Assert rst during ACCESS with 2 commands queued -> p_ce/p_sel/busy=0 asynchronously, no rsp_valid. After release, cmd_ready=1 and a new write completes normally.
6. Against the real convolution core:
   - After its 32-cycle clear, write coefficients 1..32 to addr 0..31, then read all back -> 32 rsp_rdata match, zero timeouts.
   - A write issued during the clear window times out (TIMEOUT_CYCLES=8).
